// File: rtl/flag_gen_if.sv
// Operand/flag bundle for flag_gen: the requester drives operands and start,
// the subtractor returns busy/done and the comparison flags.
interface flag_gen_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        start;
    logic        busy;
    logic        done;
    logic        result;
    logic        cout;
    logic        zero;
    logic        overflow;
    logic        sign_out;

    modport master (
        output a, b, sign, start,
        input  busy, done, result, cout, zero, overflow, sign_out
    );

    modport slave (
        input  a, b, sign, start,
        output busy, done, result, cout, zero, overflow, sign_out
    );
endinterface

// File: rtl/flag_gen.sv
// Serial LSB-first subtractor producing result/cout/zero/overflow flags.
// Define FLAG_GEN_NIBBLE_EN for a 4-bit-per-cycle datapath (default 1 bit).
module flag_gen (
    input  logic       clk,
    input  logic       reset,
    flag_gen_if.slave  bus
);

`ifdef FLAG_GEN_NIBBLE_EN
    localparam int unsigned W = 4;
`else
    localparam int unsigned W = 1;
`endif
    localparam int unsigned STEPS = 32 / W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        carry;
    logic        nonzero;
    logic        sign_q;
    logic [5:0]  step;

    logic [W-1:0] diff;
    logic         c_msb;
    logic         c_out;
    logic         c;
    logic         last;

    // Ripple through the W-bit slice; c_msb is the carry into the slice's top
    // bit, which on the final step is the carry into bit 31.
    always_comb begin
        c     = carry;
        diff  = '0;
        c_msb = carry;
        for (int unsigned i = 0; i < W; i++) begin
            diff[i] = op_a[i] ^ op_b[i] ^ c;
            if (i == W - 1) c_msb = c;
            c = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
        end
        c_out = c;
    end

    assign last = (step == 6'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            carry        <= 1'b0;
            nonzero      <= 1'b0;
            sign_q       <= 1'b0;
            step         <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= 1'b0;
            bus.cout     <= 1'b0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.sign_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_a     <= bus.a;
                        op_b     <= ~bus.b;
                        sign_q   <= bus.sign;
                        carry    <= 1'b1;
                        nonzero  <= 1'b0;
                        step     <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> W;
                    op_b    <= op_b >> W;
                    carry   <= c_out;
                    nonzero <= nonzero | (|diff);
                    if (last) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.result   <= diff[W-1];
                        bus.cout     <= c_out;
                        bus.zero     <= ~(nonzero | (|diff));
                        bus.overflow <= c_msb ^ c_out;
                        bus.sign_out <= sign_q;
                    end else begin
                        step <= step + 6'd1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_gen.sv
// Scoreboard bench for flag_gen: expected flags queued at start, checked on done.
module tb_flag_gen;

`ifdef FLAG_GEN_NIBBLE_EN
    localparam int STEPS = 8;
`else
    localparam int STEPS = 32;
`endif
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic [4:0] exp_q[$];

    flag_gen_if bus();

    flag_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] sum;
        logic [31:0] d;
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        d   = sum[31:0];
        return {d[31], sum[32], (d == 32'd0), (a[31] != b[31]) && (d[31] != a[31]), s};
    endfunction

    function automatic logic [4:0] flags();
        return {bus.result, bus.cout, bus.zero, bus.overflow, bus.sign_out};
    endfunction

    // Scoreboard: every done pulse pops one expected flag set.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            logic [4:0] e;
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got flags=%b with no pending operation", flags());
            end else begin
                e = exp_q.pop_front();
                if (flags() !== e) begin
                    failures++;
                    $display("FAIL flags: got {res,cout,zero,ovf,sign}=%b expected %b", flags(), e);
                end
            end
        end
    end

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sign = s; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sign = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {bus.busy, bus.done, flags()};
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000000", outs);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_vectors();
        logic [31:0] ta[8];
        logic [31:0] tb[8];
        logic        ts[8];
        logic [4:0]  prev;
        int          n;
        ta[0] = 32'd5;          tb[0] = 32'd5;          ts[0] = 1'b1;
        ta[1] = 32'd1;          tb[1] = 32'd2;          ts[1] = 1'b0;
        ta[2] = 32'h8000_0000;  tb[2] = 32'd1;          ts[2] = 1'b0;
        ta[3] = 32'd0;          tb[3] = 32'hFFFF_FFFF;  ts[3] = 1'b1;
        ta[4] = 32'h7FFF_FFFF;  tb[4] = 32'hFFFF_FFFF;  ts[4] = 1'b0;
        for (int k = 5; k < 8; k++) begin
            ta[k] = $urandom; tb[k] = $urandom; ts[k] = 1'($urandom_range(0, 1));
        end
        tb[7] = ta[7];
        for (int k = 0; k < 8; k++) begin
            prev = flags();
            exp_q.push_back(model(ta[k], tb[k], ts[k]));
            drive_start(ta[k], tb[k], ts[k]);
            n = -1;
            for (int i = 1; i <= BUDGET; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    n = i;
                    break;
                end
                if (i == 2) begin
                    checks++;
                    if (bus.busy !== 1'b1 || flags() !== prev) begin
                        failures++;
                        $display("FAIL run_hold[%0d]: busy=%b flags=%b expected busy=1 flags=%b", k, bus.busy, flags(), prev);
                    end
                end
            end
            checks++;
            if (n != STEPS + 1 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d cycles busy=%b expected %0d busy=1", k, n, bus.busy, STEPS + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_done: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        int d0;
        d0 = done_cnt;
        exp_q.push_back(model(32'h1234_5678, 32'h0000_5678, 1'b1));
        drive_start(32'h1234_5678, 32'h0000_5678, 1'b1);
        repeat (3) @(negedge clk);
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0001; bus.sign = 1'b0; bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n < 0) begin
            failures++;
            $display("FAIL busy_ignore_done: got timeout expected a done pulse");
        end
        repeat (STEPS + 5) @(posedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL busy_ignore_count: got %0d done pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] outs;
        int n;
        int d0;
        int abort_at;
        abort_at = (STEPS > 10) ? 10 : STEPS / 2;
        d0 = done_cnt;
        drive_start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        repeat (abort_at - 1) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.a = 32'd100; bus.b = 32'd200; bus.sign = 1'b1; bus.start = 1'b1;
        exp_q.push_back(model(32'd100, 32'd200, 1'b1));
        @(negedge clk);
        outs = {bus.busy, bus.done, flags()};
        checks++;
        if (outs !== 7'b0) begin
            failures++;
            $display("FAIL abort_outputs: got %b expected 0000000", outs);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n != STEPS + 1) begin
            failures++;
            $display("FAIL abort_restart_latency: got %0d expected %0d", n, STEPS + 1);
        end
        @(posedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL abort_done_count: got %0d done pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        exp_q.push_back(model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0));
        drive_start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(n);
        checks++;
        if (n != STEPS + 1) begin
            failures++;
            $display("FAIL b2b_first_latency: got %0d expected %0d", n, STEPS + 1);
        end
        // start raised in the DONE cycle must wait for IDLE
        bus.a = 32'h8000_0000; bus.b = 32'h7FFF_FFFF; bus.sign = 1'b1; bus.start = 1'b1;
        exp_q.push_back(model(32'h8000_0000, 32'h7FFF_FFFF, 1'b1));
        @(posedge clk);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n != STEPS + 1) begin
            failures++;
            $display("FAIL b2b_second_latency: got %0d expected %0d", n, STEPS + 1);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sign = 1'b0;
        reset = 1'b1;
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
